// File: rtl/kyber_reduce_seq_if.sv
// Stream/handshake bundle between kyber_reduce_seq, its producer/consumer and reduction_top.
// err_range_o exists only when KYBER_SEQ_RANGE_CHECK_EN is defined.
interface kyber_reduce_seq_if #(
    parameter int unsigned DATA_LENGTH = 16
);
    logic                   in_valid_i;
    logic [DATA_LENGTH-1:0] in_data_i;
    logic                   in_ready_o;
    logic                   red_start_o;
    logic [DATA_LENGTH-1:0] red_x_o;
    logic [DATA_LENGTH-1:0] red_m_o;
    logic [DATA_LENGTH-1:0] red_result_i;
    logic                   red_valid_i;
    logic                   out_valid_o;
    logic [DATA_LENGTH-1:0] out_data_o;
    logic                   out_ready_i;
    logic                   err_timeout_o;
    logic [15:0]            count_o;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
    logic                   err_range_o;
`endif

    // Sequencer side
    modport master (
        input  in_valid_i, in_data_i, red_result_i, red_valid_i, out_ready_i,
        output in_ready_o, red_start_o, red_x_o, red_m_o, out_valid_o, out_data_o,
               err_timeout_o, count_o
`ifdef KYBER_SEQ_RANGE_CHECK_EN
        , output err_range_o
`endif
    );

    // Environment side: producer, consumer and reduction core
    modport slave (
        output in_valid_i, in_data_i, red_result_i, red_valid_i, out_ready_i,
        input  in_ready_o, red_start_o, red_x_o, red_m_o, out_valid_o, out_data_o,
               err_timeout_o, count_o
`ifdef KYBER_SEQ_RANGE_CHECK_EN
        , input err_range_o
`endif
    );
endinterface

// File: rtl/kyber_reduce_seq.sv
// Initiator for reduction_top: one x mod Q reduction per streamed operand, with zero bypass
// and WAIT timeout. Define KYBER_SEQ_RANGE_CHECK_EN to add the sticky err_range_o flag.
module kyber_reduce_seq #(
    parameter int unsigned DATA_LENGTH    = 16,
    parameter int unsigned Q              = 3329,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    kyber_reduce_seq_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_LENGTH-1:0] Q_W = DATA_LENGTH'(Q);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   red_start_q, red_start_d;
    logic [DATA_LENGTH-1:0] red_x_q, red_x_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_LENGTH-1:0] out_data_q, out_data_d;
    logic                   err_timeout_q, err_timeout_d;
    logic [15:0]            count_q, count_d;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
    logic                   err_range_q, err_range_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            in_ready_q    <= 1'b1;
            red_start_q   <= 1'b0;
            red_x_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            err_timeout_q <= 1'b0;
            count_q       <= '0;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
            err_range_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            in_ready_q    <= in_ready_d;
            red_start_q   <= red_start_d;
            red_x_q       <= red_x_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            err_timeout_q <= err_timeout_d;
            count_q       <= count_d;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
            err_range_q   <= err_range_d;
`endif
        end
    end

    // Next state; handshake outputs are decoded from the next state so they are registered
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        red_x_d       = red_x_q;
        out_data_d    = out_data_q;
        err_timeout_d = err_timeout_q;
        count_d       = count_q;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
        err_range_d   = err_range_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i && in_ready_q) begin
                    red_x_d = bus.in_data_i;
                    if (bus.in_data_i == '0) begin
                        out_data_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // Core result wins over a timeout landing in the same cycle
                if (bus.red_valid_i) begin
                    out_data_d = bus.red_result_i;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
                    if (bus.red_result_i >= Q_W) err_range_d = 1'b1;
`endif
                    state_d = S_HOLD;
                end else if (wait_cnt_q == CNT_LAST) begin
                    out_data_d    = '1;
                    err_timeout_d = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (bus.out_ready_i) begin
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        red_start_d = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_HOLD);
    end

    assign bus.in_ready_o    = in_ready_q;
    assign bus.red_start_o   = red_start_q;
    assign bus.red_x_o       = red_x_q;
    assign bus.red_m_o       = Q_W;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.out_data_o    = out_data_q;
    assign bus.err_timeout_o = err_timeout_q;
    assign bus.count_o       = count_q;
`ifdef KYBER_SEQ_RANGE_CHECK_EN
    assign bus.err_range_o   = err_range_q;
`endif
endmodule

// File: tb/tb_kyber_reduce_seq.sv
// Scoreboard bench for kyber_reduce_seq with a behavioural reduction core model.
module tb_kyber_reduce_seq;
    localparam int unsigned DW       = 16;
    localparam int unsigned Q        = 3329;
    localparam int unsigned TO       = 64;
    localparam int unsigned CORE_LAT = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    kyber_reduce_seq_if #(.DATA_LENGTH(DW)) bus();

    kyber_reduce_seq #(
        .DATA_LENGTH   (DW),
        .Q             (Q),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_start   = 0;
    int          core_mode = 0;   // 0 correct, 1 silent, 2 returns Q
    logic [15:0] exp_count = '0;
    logic [DW-1:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reduction core
    initial begin : core_model
        logic [DW-1:0] x;
        bus.red_valid_i  = 1'b0;
        bus.red_result_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (rst_ni && bus.red_start_o) begin
                n_start++;
                x = bus.red_x_o;
                if (core_mode != 1) begin
                    @(posedge clk_i); #1;
                    check_eq("start_pulse", 32'(bus.red_start_o), 0);
                    repeat (CORE_LAT - 1) @(posedge clk_i);
                    #1;
                    if (rst_ni && !bus.in_ready_o) check_eq("x_stable", 32'(bus.red_x_o), 32'(x));
                    bus.red_result_i = (core_mode == 2) ? DW'(Q) : DW'(32'(x) % Q);
                    bus.red_valid_i  = 1'b1;
                    @(posedge clk_i); #1;
                    bus.red_valid_i  = 1'b0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every output handshake
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni && bus.out_valid_o && bus.out_ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("out_unexpected", 32'(sb.size()), 1);
                end else begin
                    check_eq("out_data", 32'(bus.out_data_o), 32'(sb.pop_front()));
                    check_eq("count", 32'(bus.count_o), 32'(exp_count));
                    exp_count = exp_count + 16'd1;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] exp);
        int n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = x;
        while (!bus.in_ready_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!bus.in_ready_o) check_eq("in_ready_timeout", 32'(bus.in_ready_o), 1);
        @(posedge clk_i); #1;
        bus.in_valid_i = 1'b0;
        sb.push_back(exp);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid_o && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!bus.out_valid_o) check_eq("out_valid_timeout", 32'(bus.out_valid_o), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid_o) && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_eq("drain", 32'(sb.size()), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_in_ready"},  32'(bus.in_ready_o), 1);
        check_eq({tag, "_start"},     32'(bus.red_start_o), 0);
        check_eq({tag, "_red_x"},     32'(bus.red_x_o), 0);
        check_eq({tag, "_red_m"},     32'(bus.red_m_o), Q);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid_o), 0);
        check_eq({tag, "_out_data"},  32'(bus.out_data_o), 0);
        check_eq({tag, "_timeout"},   32'(bus.err_timeout_o), 0);
        check_eq({tag, "_count"},     32'(bus.count_o), 0);
`ifdef KYBER_SEQ_RANGE_CHECK_EN
        check_eq({tag, "_range"},     32'(bus.err_range_o), 0);
`endif
    endtask

    initial begin : main
        int n;
        int s;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("rst");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Normal reduction
        send(16'h1234, 16'h0533);
        check_eq("issue_start", 32'(bus.red_start_o), 1);
        check_eq("issue_ready", 32'(bus.in_ready_o), 0);
        check_eq("issue_x", 32'(bus.red_x_o), 32'h1234);
        drain();
        check_eq("count_1", 32'(bus.count_o), 1);
        check_eq("ready_after_out", 32'(bus.in_ready_o), 1);

        // Zero bypass
        s = n_start;
        send(16'h0000, 16'h0000);
        check_eq("bypass_valid", 32'(bus.out_valid_o), 1);
        check_eq("bypass_data", 32'(bus.out_data_o), 0);
        check_eq("bypass_start", 32'(bus.red_start_o), 0);
        drain();
        check_eq("bypass_no_core", n_start, s);

        // Back-to-back operands
        send(16'd3329, 16'h0000);
        check_eq("b2b_ready_a", 32'(bus.in_ready_o), 0);
        send(16'hFFFF, 16'h08EC);
        check_eq("b2b_ready_b", 32'(bus.in_ready_o), 0);
        drain();

        // Backpressure in HOLD
        bus.out_ready_i = 1'b0;
        send(16'h1234, 16'h0533);
        wait_valid(n);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 16'h0007;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            check_eq("hold_valid", 32'(bus.out_valid_o), 1);
            check_eq("hold_data", 32'(bus.out_data_o), 32'h0533);
            check_eq("hold_ready", 32'(bus.in_ready_o), 0);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        drain();
        check_eq("count_hold", 32'(bus.count_o), 5);

        // Silent core -> timeout
        core_mode = 1;
        send(16'h1234, 16'hFFFF);
        wait_valid(n);
        check_eq("timeout_latency", n, TO + 1);
        check_eq("timeout_flag", 32'(bus.err_timeout_o), 1);
        drain();
        core_mode = 0;
        send(16'h1234, 16'h0533);
        drain();
        check_eq("timeout_sticky", 32'(bus.err_timeout_o), 1);

        // Reset during WAIT
        send(16'h1234, 16'h0533);
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        check_reset_values("midrst");
        sb.delete();
        exp_count = '0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            check_eq("late_valid_ignored", 32'(bus.out_valid_o), 0);
        end
        send(16'h0ABC, 16'h0ABC);
        drain();
        check_eq("count_after_rst", 32'(bus.count_o), 1);

`ifdef KYBER_SEQ_RANGE_CHECK_EN
        // Out-of-range core result is flagged and forwarded
        core_mode = 2;
        send(16'h0100, DW'(Q));
        drain();
        check_eq("range_flag", 32'(bus.err_range_o), 1);
        core_mode = 0;
`endif

        check_eq("count_final", 32'(bus.count_o), 32'(exp_count));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
